// File: rtl/sram_128x7_ctrl_if.sv
// Request/response bundle between a client and sram_128x7_ctrl.
//   master : client side (drives write/read requests, receives ready and read data)
//   slave  : controller side
// Signals: wr_valid/wr_ready/wr_addr/wr_data, rd_valid/rd_ready/rd_addr,
//          rd_resp_valid/rd_resp_data.
interface sram_128x7_ctrl_if #(
  parameter int Bits      = 7,
  parameter int Add_Width = 7
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [Add_Width-1:0] wr_addr;
  logic [Bits-1:0]      wr_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [Add_Width-1:0] rd_addr;
  logic                 rd_resp_valid;
  logic [Bits-1:0]      rd_resp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data
  );
endinterface

// File: rtl/sram_128x7_ctrl.sv
// Controller in front of a 128x7 single-port SRAM macro.
// After reset it writes INIT_DATA to every entry, then arbitrates one write
// and one read port onto the single SRAM port (write wins). Read data comes
// back one cycle after acceptance and is held stable between responses.
//
// Ports:
//   CLK, RSTB            clock, asynchronous active-low reset
//   flush                re-run initialisation (only with SRAM_CTRL_FLUSH_EN)
//   bus                  request/response interface (slave modport)
//   init_done            high once every entry has been initialised
//   sram_ceb/web/a/d     SRAM macro pins (CEB, WEB active low)
//   sram_q               SRAM macro read data (valid only after a read)
//
// Optional feature macro: SRAM_CTRL_FLUSH_EN adds the flush input.
module sram_128x7_ctrl #(
  parameter int              Bits       = 7,
  parameter int              Word_Depth = 128,
  parameter int              Add_Width  = 7,
  parameter logic [Bits-1:0] INIT_DATA  = '0
) (
  input  logic                 CLK,
  input  logic                 RSTB,
`ifdef SRAM_CTRL_FLUSH_EN
  input  logic                 flush,
`endif
  sram_128x7_ctrl_if.slave     bus,
  output logic                 init_done,
  output logic                 sram_ceb,
  output logic                 sram_web,
  output logic [Add_Width-1:0] sram_a,
  output logic [Bits-1:0]      sram_d,
  input  logic [Bits-1:0]      sram_q
);

  localparam logic [Add_Width-1:0] LAST_ADDR = Add_Width'(Word_Depth - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t               state;
  logic [Add_Width-1:0] init_cnt;
  logic                 resp_vld;
  logic [Bits-1:0]      hold_q;
  logic                 flush_req;
  logic                 in_idle;
  logic                 wr_acc;
  logic                 rd_acc;

`ifdef SRAM_CTRL_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_idle = (state == ST_IDLE);

  // flush outranks both requests; write outranks read.
  assign bus.wr_ready = in_idle & ~flush_req;
  assign bus.rd_ready = in_idle & ~flush_req & ~bus.wr_valid;
  assign wr_acc       = bus.wr_valid & bus.wr_ready;
  assign rd_acc       = bus.rd_valid & bus.rd_ready;

  // SRAM pins follow the accepted request in the same cycle.
  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (!in_idle) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = init_cnt;
      sram_d   = INIT_DATA;
    end else if (wr_acc) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = bus.wr_addr;
      sram_d   = bus.wr_data;
    end else if (rd_acc) begin
      sram_ceb = 1'b0;
      sram_a   = bus.rd_addr;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (flush_req) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Q is only meaningful the cycle after a read; capture it then so the
  // response data never shows garbage Q on other cycles. A response pending
  // when flush hits is still delivered.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      resp_vld <= 1'b0;
      hold_q   <= '0;
    end else begin
      resp_vld <= rd_acc;
      if (resp_vld) hold_q <= sram_q;
    end
  end

  assign bus.rd_resp_valid = resp_vld;
  assign bus.rd_resp_data  = resp_vld ? sram_q : hold_q;

endmodule

// File: tb/tb_sram_128x7_ctrl.sv
// Bench for sram_128x7_ctrl: a behavioural SRAM macro (Q is random garbage on
// cycles not following a read), a reference model of the controller's
// contents/handshake checked every cycle, and directed literal checks.
module tb_sram_128x7_ctrl;

`ifdef SRAM_CTRL_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       CLK  = 1'b0;
  logic       RSTB = 1'b0;
  logic       flush = 1'b0;
  logic       init_done, sram_ceb, sram_web;
  logic [6:0] sram_a, sram_d, sram_q;

  sram_128x7_ctrl_if #(.Bits(7), .Add_Width(7)) bus();

  always #5 CLK = ~CLK;

  sram_128x7_ctrl dut (
    .CLK      (CLK),
    .RSTB     (RSTB),
`ifdef SRAM_CTRL_FLUSH_EN
    .flush    (flush),
`endif
    .bus      (bus),
    .init_done(init_done),
    .sram_ceb (sram_ceb),
    .sram_web (sram_web),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_q   (sram_q)
  );

  // Behavioural SRAM macro.
  logic [6:0] smem [128];
  logic [6:0] q_r  = 7'h0;
  logic [6:0] garb = 7'h0;
  logic       q_ok = 1'b0;
  always @(posedge CLK) begin
    q_ok <= !sram_ceb && sram_web;
    garb <= 7'($urandom);
    if (!sram_ceb) begin
      if (!sram_web) smem[sram_a] <= sram_d;
      else           q_r <= smem[sram_a];
    end
  end
  assign sram_q = q_ok ? q_r : garb;

  int nchk = 0;
  int nerr = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entries, init progress, pending response, held data.
  int         m_cnt = 0;     // init writes done; 128 means idle
  bit         m_pend = 1'b0;
  logic [6:0] m_pdata = 7'h0;
  logic [6:0] m_hold = 7'h0;
  logic [6:0] ref_mem [128];
  bit         eidle, fl, wacc, racc, nxt_pend;
  logic [6:0] nxt_data;

  always @(negedge CLK) begin
    if (!RSTB) begin
      m_cnt = 0; m_pend = 1'b0; m_hold = 7'h0;
      check("rst_init_done", init_done, 0);
      check("rst_resp_valid", bus.rd_resp_valid, 0);
      check("rst_resp_data", bus.rd_resp_data, 0);
      check("rst_ready", {bus.wr_ready, bus.rd_ready}, 0);
    end else begin
      eidle = (m_cnt >= 128);
      fl    = FL && flush && eidle;
      wacc  = eidle && !fl && bus.wr_valid;
      racc  = eidle && !fl && !bus.wr_valid && bus.rd_valid;
      check("init_done", init_done, eidle);
      check("wr_ready", bus.wr_ready, eidle && !fl);
      check("rd_ready", bus.rd_ready, eidle && !fl && !bus.wr_valid);
      check("resp_valid", bus.rd_resp_valid, m_pend);
      check("resp_data", bus.rd_resp_data, m_pend ? m_pdata : m_hold);
      if (!eidle)
        check("init_pins", {sram_ceb, sram_web, sram_a, sram_d}, {2'b00, 7'(m_cnt), 7'h0});
      else if (wacc)
        check("wr_pins", {sram_ceb, sram_web, sram_a, sram_d}, {2'b00, bus.wr_addr, bus.wr_data});
      else if (racc)
        check("rd_pins", {sram_ceb, sram_web, sram_a, sram_d}, {2'b01, bus.rd_addr, 7'h0});
      else
        check("idle_pins", {sram_ceb, sram_web, sram_a, sram_d}, {2'b11, 14'h0});
      nxt_pend = racc;
      nxt_data = racc ? ref_mem[bus.rd_addr] : 7'h0;
      if (!eidle) begin
        ref_mem[m_cnt] = 7'h0;
        m_cnt++;
      end else if (fl) m_cnt = 0;
      else if (wacc) ref_mem[bus.wr_addr] = bus.wr_data;
      if (m_pend) m_hold = m_pdata;
      m_pend  = nxt_pend;
      m_pdata = nxt_data;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_valid = 1'b0; bus.wr_addr = 7'h0; bus.wr_data = 7'h0;
    bus.rd_valid = 1'b0; bus.rd_addr = 7'h0;
  endtask

  task automatic wr(logic [6:0] a, logic [6:0] d);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step(1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd_chk(string nm, logic [6:0] a, logic [6:0] exp);
    bus.rd_valid = 1'b1; bus.rd_addr = a;
    #1;
    check({nm, "_rd_ready"}, bus.rd_ready, 1);
    step(1);
    bus.rd_valid = 1'b0;
    #1;
    check({nm, "_resp_valid"}, bus.rd_resp_valid, 1);
    check({nm, "_resp_data"}, bus.rd_resp_data, exp);
  endtask

  initial begin
    idle_in();
    RSTB = 1'b0;
    step(3);
    RSTB = 1'b1;                       // cycle 1 of init
    #1;
    check("c1_pins", {sram_ceb, sram_web, sram_a}, {2'b00, 7'd0});
    for (int i = 1; i < 128; i++) begin
      bus.wr_valid = 1'($urandom); bus.rd_valid = 1'($urandom);
      step(1);
    end                                // cycle 128
    check("c128_init_done", init_done, 0);
    check("c128_addr", sram_a, 127);
    idle_in();
    step(1);                           // cycle 129
    check("c129_init_done", init_done, 1);

    wr(7'd5, 7'h2A);
    rd_chk("wr5_rd5", 7'd5, 7'h2A);

    // Write and read together: write wins, read goes next cycle.
    bus.wr_valid = 1'b1; bus.wr_addr = 7'd3; bus.wr_data = 7'h11;
    bus.rd_valid = 1'b1; bus.rd_addr = 7'd3;
    #1;
    check("conf_rd_ready", bus.rd_ready, 0);
    check("conf_wr_ready", bus.wr_ready, 1);
    step(1);
    bus.wr_valid = 1'b0;
    #1;
    check("conf_rd_ready2", bus.rd_ready, 1);
    step(1);
    bus.rd_valid = 1'b0;
    #1;
    check("conf_resp", {bus.rd_resp_valid, bus.rd_resp_data}, {1'b1, 7'h11});

    // Back-to-back reads, then hold while idle.
    wr(7'd1, 7'h01); wr(7'd2, 7'h02); wr(7'd3, 7'h03);
    bus.rd_valid = 1'b1; bus.rd_addr = 7'd1;
    step(1);
    bus.rd_addr = 7'd2;
    #1 check("b2b_1", {bus.rd_resp_valid, bus.rd_resp_data}, {1'b1, 7'h01});
    step(1);
    bus.rd_addr = 7'd3;
    #1 check("b2b_2", {bus.rd_resp_valid, bus.rd_resp_data}, {1'b1, 7'h02});
    step(1);
    bus.rd_valid = 1'b0;
    #1 check("b2b_3", {bus.rd_resp_valid, bus.rd_resp_data}, {1'b1, 7'h03});
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("hold", {bus.rd_resp_valid, bus.rd_resp_data, sram_ceb}, {1'b0, 7'h03, 1'b1});
    end

    // Reset in the middle of init.
    RSTB = 1'b0;
    step(1);
    RSTB = 1'b1;
    step(60);                          // init counter now 60
    check("mid_addr60", sram_a, 60);
    RSTB = 1'b0;
    #1;
    check("mid_rst_done", {init_done, bus.rd_ready, bus.wr_ready}, 0);
    step(2);
    RSTB = 1'b1;
    #1;
    check("restart_addr0", {sram_ceb, sram_web, sram_a}, {2'b00, 7'd0});
    step(127);
    check("restart_c128", {init_done, sram_a}, {1'b0, 7'd127});
    step(1);
    check("restart_c129", init_done, 1);
    rd_chk("after_reinit", 7'd3, 7'h00);

    if (FL) begin
      wr(7'd9, 7'h7F);
      rd_chk("fl_pre", 7'd9, 7'h7F);
      flush = 1'b1;
      bus.wr_valid = 1'b1; bus.wr_addr = 7'd9; bus.wr_data = 7'h55;
      #1;
      check("fl_wr_ready", bus.wr_ready, 0);
      step(1);
      flush = 1'b0; bus.wr_valid = 1'b0;
      #1;
      check("fl_done_low", init_done, 0);
      step(127);
      check("fl_done_c128", init_done, 0);
      step(1);
      check("fl_done_c129", init_done, 1);
      rd_chk("fl_post", 7'd9, 7'h00);
    end

    // Random traffic on a small address window to force reuse.
    for (int i = 0; i < 600; i++) begin
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_addr  = 7'($urandom_range(0, 15));
      bus.wr_data  = 7'($urandom);
      bus.rd_valid = ($urandom_range(0, 1) == 0);
      bus.rd_addr  = 7'($urandom_range(0, 15));
      flush        = FL && ($urandom_range(0, 79) == 0);
      step(1);
    end
    idle_in();
    flush = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
